alu_multiword_sequencer: RTL and testbench
==========================================

# alu_multiword_sequencer

Sequences one Width-bit SIMD ALU slice across NUM_WORDS cycles to execute a (NUM_WORDS*Width)-bit arithmetic or logic operation. Word 0 (LSW) is processed first, and the adder carry is chained between words. The block sits between a requester with a valid/ready request channel and the combinational ALU. It drives every ALU control and operand port and collects the ALU result words into a response held under valid/ready backpressure.

## Interface
- Width, 8, ALU slice width in bits.
- NUM_WORDS, 4, words per operation; must be ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  3  000 ADD, 001 SUB (a−b), 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 XNOR.
- req_a, req_b  in  Width*NUM_WORDS  operands; word k is bits [k*Width +: Width].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  Width*NUM_WORDS  result.
- resp_carry  out  1  final carry: ADD carry-out; SUB not-borrow, i.e. 1 iff a≥b unsigned; 0 for logic ops.
- resp_overflow  out  1  signed overflow (ALU_SEQ_OVERFLOW_EN only).
- alu_W, alu_Y  out  Width  tied to 0.
- alu_X, alu_Z  out  Width  operand A word k and operand B word k.
- alu_op  out  2  00 ADD/SUB, 01 XOR/XNOR, 10 AND/NAND, 11 OR/NOR.
- alu_Z_controller  out  1  1 for SUB only; the ALU inverts Z.
- alu_S_controller  out  1  1 for NAND/NOR/XNOR; the ALU inverts S.
- alu_W_X_Y_controller  out  1  tied to 0.
- alu_CIN_W_X_Y_CIN  out  2  tied to 0.
- alu_CIN_Z_W_X_Y_CIN  out  1  the carry register.
- alu_S  in  Width  ALU result for the current word, combinational.
- alu_COUT_Z_W_X_Y_CIN  in  1  ALU carry-out for the current word.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - All alu_* outputs are 0.
  - On req_valid: latch op, a and b; word index k←0; carry←1 for SUB, else 0; go to RUN.
- RUN:
  - Drive word k onto the ALU and the op-decoded controls.
  - Each edge: result word k←alu_S.
  - For ADD/SUB each edge: carry←alu_COUT_Z_W_X_Y_CIN. For logic ops the carry stays 0.
  - k increments each edge. When k=NUM_WORDS−1, go to DONE.
- DONE:
  - resp_valid=1; resp_result, resp_carry and resp_overflow are held stable.
  - On resp_ready go to IDLE.
- resp_carry equals the carry register.
- Result bits for words not yet processed are don't-care until DONE.
- rst in any state:
  - Next state IDLE.
  - k, carry, result and latched operands cleared.
  - Any in-flight operation is discarded with no response.
- Reset values of all outputs: req_ready=1; resp_valid=0; resp_result=0; resp_carry=0; resp_overflow=0; all alu_* outputs 0.
- req_valid outside IDLE is ignored. The requester holds the request until req_ready is observed.

## Timing
- Request accepted at edge T (req_valid & req_ready).
- Words 0..NUM_WORDS−1 are on the ALU in cycles T+1..T+NUM_WORDS.
- resp_valid rises in cycle T+NUM_WORDS+1, i.e. latency NUM_WORDS+1 cycles.
- DONE→IDLE on the resp handshake edge. req_ready is high the following cycle.
- Minimum request-to-request spacing is NUM_WORDS+2 cycles.
- The ALU path is combinational and must close within one cycle. alu_S is sampled at the same edge that advances k.

## Configuration
- Macro ALU_SEQ_OVERFLOW_EN.
- Defined:
  - resp_overflow is a registered output, captured on the final RUN edge.
  - ADD: (a_msb==b_msb)&(r_msb!=a_msb).
  - SUB: (a_msb!=b_msb)&(r_msb!=a_msb).
  - Logic ops: 0.
  - msb is bit Width*NUM_WORDS−1.
- Undefined:
  - The resp_overflow port is absent.
  - No overflow logic is built.

## Test plan
Bench instantiates the ALU, with Width=8 and NUM_WORDS=4.
- ADD a=0x000000FF, b=0x00000001 -> result 0x00000100, carry 0; resp_valid exactly 5 cycles after acceptance.
- ADD a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, carry 1, overflow 0.
- SUB a=0x00000000, b=0x00000001 -> result 0xFFFFFFFF, carry 0, overflow 0. SUB a=0x80000000, b=0x00000001 -> result 0x7FFFFFFF, carry 1, overflow 1.
- NAND a=0xF0F0F0F0, b=0xFF00FF00 -> result 0x0FFF0FFF, carry 0. XNOR of same -> 0xF00FF00F.
- Backpressure: resp_ready low 3 cycles in DONE -> result stable, req_ready 0. A req_valid held high is accepted the cycle after the resp handshake.
- rst for one cycle while k=2 -> next cycle IDLE, req_ready=1, resp_valid=0, all alu_* outputs 0; no response ever emitted for that request.

Source files
------------

// File: rtl/alu_multiword_sequencer.sv
// alu_multiword_sequencer
// Runs one Width-bit ALU slice over NUM_WORDS cycles to perform a
// (Width*NUM_WORDS)-bit add/sub/logic operation, LSW first, with the adder
// carry chained between words through alu_CIN_Z_W_X_Y_CIN.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a, req_b payload
//   resp_valid/resp_ready    response handshake; resp_result, resp_carry
//   resp_overflow            signed overflow (only with ALU_SEQ_OVERFLOW_EN)
//   alu_*  (out)             operand words and controls for the ALU slice
//   alu_S, alu_COUT_Z_W_X_Y_CIN (in)  combinational ALU result / carry-out
//
// Optional feature macro: ALU_SEQ_OVERFLOW_EN (adds resp_overflow).
module alu_multiword_sequencer #(
  parameter int unsigned Width     = 8,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_op,
  input  logic [Width*NUM_WORDS-1:0]   req_a,
  input  logic [Width*NUM_WORDS-1:0]   req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [Width*NUM_WORDS-1:0]   resp_result,
  output logic                         resp_carry,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic                         resp_overflow,
`endif
  output logic [Width-1:0]             alu_W,
  output logic [Width-1:0]             alu_X,
  output logic [Width-1:0]             alu_Y,
  output logic [Width-1:0]             alu_Z,
  output logic [1:0]                   alu_op,
  output logic                         alu_Z_controller,
  output logic                         alu_S_controller,
  output logic                         alu_W_X_Y_controller,
  output logic [1:0]                   alu_CIN_W_X_Y_CIN,
  output logic                         alu_CIN_Z_W_X_Y_CIN,
  input  logic [Width-1:0]             alu_S,
  input  logic                         alu_COUT_Z_W_X_Y_CIN
);

  localparam int unsigned TotalW = Width * NUM_WORDS;
  localparam int unsigned KW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] LastK = KW'(NUM_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              carry_q, carry_d;
  logic [TotalW-1:0] res_q, res_d;
  logic [TotalW-1:0] a_q, a_d;
  logic [TotalW-1:0] b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [Width-1:0]  alu_x_q, alu_x_d;
  logic [Width-1:0]  alu_z_q, alu_z_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              alu_zc_q, alu_zc_d;
  logic              alu_sc_q, alu_sc_d;
  logic              alu_cin_q, alu_cin_d;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  // Op decode: in IDLE decode the incoming request so word 0 controls are
  // registered on the accept edge; afterwards decode the latched op.
  logic [2:0] dec_op;
  logic [1:0] dec_alu_op;
  logic       dec_zc;
  logic       dec_sc;
  logic       dec_arith;

  always_comb begin
    dec_op     = (state_q == S_IDLE) ? req_op : op_q;
    dec_alu_op = 2'b00;
    unique case (dec_op)
      3'b000, 3'b001: dec_alu_op = 2'b00;
      3'b100, 3'b111: dec_alu_op = 2'b01;
      3'b010, 3'b101: dec_alu_op = 2'b10;
      3'b011, 3'b110: dec_alu_op = 2'b11;
      default:        dec_alu_op = 2'b00;
    endcase
    dec_zc    = (dec_op == OP_SUB);
    dec_sc    = (dec_op >= 3'b101);
    dec_arith = (dec_op[2:1] == 2'b00);
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    res_d     = res_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    alu_x_d   = '0;
    alu_z_d   = '0;
    alu_op_d  = 2'b00;
    alu_zc_d  = 1'b0;
    alu_sc_d  = 1'b0;
    alu_cin_d = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          a_d       = req_a;
          b_d       = req_b;
          k_d       = '0;
          carry_d   = (req_op == OP_SUB);
          state_d   = S_RUN;
          alu_x_d   = req_a[Width-1:0];
          alu_z_d   = req_b[Width-1:0];
          alu_op_d  = dec_alu_op;
          alu_zc_d  = dec_zc;
          alu_sc_d  = dec_sc;
          alu_cin_d = carry_d;
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf_d     = 1'b0;
`endif
        end
      end

      S_RUN: begin
        res_d[k_q*Width +: Width] = alu_S;
        if (dec_arith) carry_d = alu_COUT_Z_W_X_Y_CIN;
        k_d = k_q + KW'(1);
        if (k_q == LastK) begin
          state_d = S_DONE;
`ifdef ALU_SEQ_OVERFLOW_EN
          // Sign of operands vs. sign of final result word's top bit
          if (op_q == OP_ADD)
            ovf_d = (a_q[TotalW-1] == b_q[TotalW-1]) && (alu_S[Width-1] != a_q[TotalW-1]);
          else if (op_q == OP_SUB)
            ovf_d = (a_q[TotalW-1] != b_q[TotalW-1]) && (alu_S[Width-1] != a_q[TotalW-1]);
          else
            ovf_d = 1'b0;
`endif
        end else begin
          alu_x_d   = a_q[k_d*Width +: Width];
          alu_z_d   = b_q[k_d*Width +: Width];
          alu_op_d  = dec_alu_op;
          alu_zc_d  = dec_zc;
          alu_sc_d  = dec_sc;
          alu_cin_d = carry_d;
        end
      end

      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      carry_q      <= 1'b0;
      res_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 3'b000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      alu_x_q      <= '0;
      alu_z_q      <= '0;
      alu_op_q     <= 2'b00;
      alu_zc_q     <= 1'b0;
      alu_sc_q     <= 1'b0;
      alu_cin_q    <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      carry_q      <= carry_d;
      res_q        <= res_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      alu_x_q      <= alu_x_d;
      alu_z_q      <= alu_z_d;
      alu_op_q     <= alu_op_d;
      alu_zc_q     <= alu_zc_d;
      alu_sc_q     <= alu_sc_d;
      alu_cin_q    <= alu_cin_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign req_ready            = req_ready_q;
  assign resp_valid           = resp_valid_q;
  assign resp_result          = res_q;
  assign resp_carry           = carry_q;
`ifdef ALU_SEQ_OVERFLOW_EN
  assign resp_overflow        = ovf_q;
`endif
  assign alu_W                = '0;
  assign alu_Y                = '0;
  assign alu_X                = alu_x_q;
  assign alu_Z                = alu_z_q;
  assign alu_op               = alu_op_q;
  assign alu_Z_controller     = alu_zc_q;
  assign alu_S_controller     = alu_sc_q;
  assign alu_W_X_Y_controller = 1'b0;
  assign alu_CIN_W_X_Y_CIN    = 2'b00;
  // alu_cin_q mirrors the carry register while RUN, and is 0 elsewhere
  assign alu_CIN_Z_W_X_Y_CIN  = alu_cin_q;

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Testbench for alu_multiword_sequencer (Width=8, NUM_WORDS=4) with a
// behavioural ALU slice and a whole-word arithmetic reference model.
module tb_alu_multiword_sequencer;

  logic        clk, rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_carry;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, resp_result;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic        resp_overflow;
`endif
  logic [7:0]  alu_W, alu_X, alu_Y, alu_Z, alu_S;
  logic [1:0]  alu_op, alu_CIN_W_X_Y_CIN;
  logic        alu_Z_controller, alu_S_controller, alu_W_X_Y_controller;
  logic        alu_CIN_Z_W_X_Y_CIN, alu_COUT_Z_W_X_Y_CIN;
  logic [39:0] alu_bus;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multiword_sequencer #(.Width(8), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry),
`ifdef ALU_SEQ_OVERFLOW_EN
    .resp_overflow(resp_overflow),
`endif
    .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y), .alu_Z(alu_Z),
    .alu_op(alu_op), .alu_Z_controller(alu_Z_controller),
    .alu_S_controller(alu_S_controller),
    .alu_W_X_Y_controller(alu_W_X_Y_controller),
    .alu_CIN_W_X_Y_CIN(alu_CIN_W_X_Y_CIN),
    .alu_CIN_Z_W_X_Y_CIN(alu_CIN_Z_W_X_Y_CIN),
    .alu_S(alu_S), .alu_COUT_Z_W_X_Y_CIN(alu_COUT_Z_W_X_Y_CIN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU slice
  logic [7:0] z_eff, s_raw;
  always_comb begin
    z_eff = alu_Z_controller ? ~alu_Z : alu_Z;
    s_raw = 8'h00;
    alu_COUT_Z_W_X_Y_CIN = 1'b0;
    case (alu_op)
      2'b00: {alu_COUT_Z_W_X_Y_CIN, s_raw} = {1'b0, alu_X} + {1'b0, z_eff} + 9'(alu_CIN_Z_W_X_Y_CIN);
      2'b01: s_raw = alu_X ^ z_eff;
      2'b10: s_raw = alu_X & z_eff;
      default: s_raw = alu_X | z_eff;
    endcase
    alu_S = alu_S_controller ? ~s_raw : s_raw;
  end

  assign alu_bus = {alu_W, alu_X, alu_Y, alu_Z, alu_op, alu_Z_controller, alu_S_controller,
                    alu_W_X_Y_controller, alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN};

  // Whole-operand reference
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c);
    c = 1'b0;
    case (op)
      3'd0: {c, r} = {1'b0, a} + {1'b0, b};
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = ~(a ^ b);
    endcase
  endfunction

`ifdef ALU_SEQ_OVERFLOW_EN
  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s, maxv, minv;
    maxv = 64'sh7FFF_FFFF;
    minv = -maxv - 1;
    if (op == 3'd0)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 3'd1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > maxv) || (s < minv);
  endfunction
`endif

  // Carry entering word w: carry out of the low w words of the operation
  function automatic logic ref_cin(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] m, s;
    m = (64'd1 << (8 * w)) - 64'd1;
    if (op == 3'd0)      s = (64'(a) & m) + (64'(b) & m);
    else if (op == 3'd1) s = (64'(a) & m) + ((~64'(b)) & m) + 64'd1;
    else return 1'b0;
    return s[8 * w];
  endfunction

  function automatic logic [1:0] exp_aluop(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 2'b00;
      3'd4, 3'd7: return 2'b01;
      3'd2, 3'd5: return 2'b10;
      default:    return 2'b11;
    endcase
  endfunction

  function automatic logic [39:0] exp_bus(input logic [2:0] op, input logic [7:0] aw, input logic [7:0] bw, input logic cin);
    return {8'h00, aw, 8'h00, bw, exp_aluop(op), (op == 3'd1), (op >= 3'd5), 1'b0, 2'b00, cin};
  endfunction

  // One full transaction; optionally presents the next request during DONE
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int bp,
                       input bit chain, input logic [2:0] nop, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] er;
    logic        ec;
    logic [39:0] eb;
    ref_model(op, a, b, er, ec);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL req_ready_idle: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      eb = exp_bus(op, a[w*8 +: 8], b[w*8 +: 8], ref_cin(op, a, b, w));
      n_cmp++;
      if (alu_bus !== eb) begin n_bad++; $display("FAIL alu_word%0d op=%0d: got %h expected %h", w, op, alu_bus, eb); end
      n_cmp++;
      if ({req_ready, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL run_handshake w=%0d: got %b expected 00", w, {req_ready, resp_valid}); end
      @(negedge clk);
    end
    n_cmp++;
    if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL latency: resp_valid got %b expected 1", resp_valid); end
    n_cmp++;
    if (resp_result !== er) begin n_bad++; $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, resp_result, er); end
    n_cmp++;
    if (resp_carry !== ec) begin n_bad++; $display("FAIL carry op=%0d a=%h b=%h: got %b expected %b", op, a, b, resp_carry, ec); end
`ifdef ALU_SEQ_OVERFLOW_EN
    n_cmp++;
    if (resp_overflow !== ref_ovf(op, a, b)) begin n_bad++; $display("FAIL overflow op=%0d a=%h b=%h: got %b expected %b", op, a, b, resp_overflow, ref_ovf(op, a, b)); end
`endif
    if (chain) begin req_valid = 1'b1; req_op = nop; req_a = na; req_b = nb; end
    for (int i = 0; i < bp; i++) begin
      resp_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({resp_valid, req_ready, resp_carry, resp_result, alu_bus} !== {2'b10, ec, er, 40'h0}) begin
        n_bad++; $display("FAIL hold%0d: got v=%b r=%b c=%b res=%h alu=%h expected v=1 r=0 c=%b res=%h alu=0",
                          i, resp_valid, req_ready, resp_carry, resp_result, alu_bus, ec, er);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid, alu_bus} !== {2'b10, 40'h0}) begin
      n_bad++; $display("FAIL after_handshake: got r=%b v=%b alu=%h expected r=1 v=0 alu=0", req_ready, resp_valid, alu_bus);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_carry} !== 3'b100) begin n_bad++; $display("FAIL reset_hs: got %b expected 100", {req_ready, resp_valid, resp_carry}); end
    n_cmp++;
    if (resp_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", resp_result); end
    n_cmp++;
    if (alu_bus !== 40'h0) begin n_bad++; $display("FAIL reset_alu: got %h expected 0", alu_bus); end
`ifdef ALU_SEQ_OVERFLOW_EN
    n_cmp++;
    if (resp_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", resp_overflow); end
`endif
  endtask

  task automatic test_directed;
    do_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 0, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd1, 32'h0000_0000, 32'h0000_0001, 0, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd1, 32'h8000_0000, 32'h0000_0001, 0, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_backpressure;
    do_op(3'd0, $urandom, $urandom, 3, 1'b0, 3'd0, 32'h0, 32'h0);
    do_op(3'd6, $urandom, $urandom, 3, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    do_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, 1'b1, 3'd1, 32'h1234_5678, 32'h1234_5679);
    do_op(3'd1, 32'h1234_5678, 32'h1234_5679, 0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_random;
    logic [2:0]  op, nop;
    logic [31:0] a, b, na, nb;
    op = 3'($urandom); a = $urandom; b = $urandom;
    for (int i = 0; i < 40; i++) begin
      nop = 3'($urandom); na = $urandom; nb = $urandom;
      if (i % 5 == 0) nb = na;
      do_op(op, a, b, int'($urandom_range(0, 2)), 1'($urandom), nop, na, nb);
      op = nop; a = na; b = nb;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_midop_reset;
    req_valid = 1'b1; req_op = 3'd0; req_a = $urandom; req_b = $urandom;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (alu_X !== req_a[23:16]) begin n_bad++; $display("FAIL midop_word2: got %h expected %h", alu_X, req_a[23:16]); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid, resp_carry, resp_result, alu_bus} !== {3'b100, 32'h0, 40'h0}) begin
      n_bad++; $display("FAIL midop_reset: got r=%b v=%b c=%b res=%h alu=%h expected r=1 v=0 c=0 res=0 alu=0",
                        req_ready, resp_valid, resp_carry, resp_result, alu_bus);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midop_no_resp%0d: got %b expected 0", i, resp_valid); end
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
